// File: rtl/ins_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ins_seq_pkg
// Purpose : Shared types and constants for the RV32I instruction sequencer:
//           sequencer state encoding, RV32I major opcodes, default reset and
//           trap vectors, and a small PC helper.
// Revision: 1.0 - initial release
// ============================================================================
package ins_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;

  // RV32I major opcodes (inst[6:0]) as seen by the decode/execute units.
  localparam logic [6:0] RV32I_OP_LUI    = 7'b0110111;
  localparam logic [6:0] RV32I_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV32I_OP_JAL    = 7'b1101111;
  localparam logic [6:0] RV32I_OP_JALR   = 7'b1100111;
  localparam logic [6:0] RV32I_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32I_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] RV32I_OP_STORE  = 7'b0100011;
  localparam logic [6:0] RV32I_OP_IMM    = 7'b0010011;
  localparam logic [6:0] RV32I_OP_REG    = 7'b0110011;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : ins_seq_if
// Purpose : Bundle of the sequencer's fetch, execute and writeback signals.
//   master : sequencer side (drives imem_req/addr, ins, pc, exec_op, rf_*,
//            trap/trap_pc; receives imem_ack/rdata, exec_busy, reg_*)
//   slave  : memory / execute units / register file side
// Revision: 1.0 - initial release
// ============================================================================
interface ins_seq_if;
  import ins_seq_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        exec_op;
  logic        exec_busy;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        trap;
  logic [31:0] trap_pc;

  modport master (
    output imem_req, imem_addr, ins, pc, exec_op, rf_we, rf_waddr, rf_wdata,
           trap, trap_pc,
    input  imem_ack, imem_rdata, exec_busy, reg_pc_w_op, reg_pc_w_val,
           reg_w_op, reg_w_reg_idx, reg_w_reg_val
  );

  modport slave (
    input  imem_req, imem_addr, ins, pc, exec_op, rf_we, rf_waddr, rf_wdata,
           trap, trap_pc,
    output imem_ack, imem_rdata, exec_busy, reg_pc_w_op, reg_pc_w_val,
           reg_w_op, reg_w_reg_idx, reg_w_reg_val
  );

endinterface
`default_nettype wire

// File: rtl/ins_seq_pc.sv
`default_nettype none
// ============================================================================
// Module  : ins_seq_pc
// Purpose : Program counter register with next-PC selection (+4, captured
//           branch/jump target, trap vector) and target misalignment check.
//   clk, rst   : clock, asynchronous active-high reset (pc <= RESET_PC)
//   adv        : leaving writeback; advance or redirect the PC
//   load_trap  : leaving trap; load TRAP_VEC
//   tgt_op     : captured PC-write request
//   tgt_val    : captured PC-write target
//   pc         : current PC
//   misalign   : taken target has nonzero bits [1:0]
// Config  : INS_SEQ_MISALIGN_TRAP_EN enables the misalignment check; when
//           undefined misalign is tied 0 (targets arrive pre-aligned).
// Revision: 1.0 - initial release
// ============================================================================
module ins_seq_pc
  import ins_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic        load_trap,
  input  logic        tgt_op,
  input  logic [31:0] tgt_val,
  output logic [31:0] pc,
  output logic        misalign
);

  logic [31:0] pc_q, pc_d;

`ifdef INS_SEQ_MISALIGN_TRAP_EN
  assign misalign = tgt_op && (tgt_val[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned target holds the PC so trap_pc can report the faulting
  // instruction; the trap state then loads the vector.
  always_comb begin
    pc_d = pc_q;
    if (load_trap) begin
      pc_d = TRAP_VEC;
    end else if (adv && !misalign) begin
      pc_d = tgt_op ? tgt_val : pc_plus4(pc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/ins_seq.sv
`default_nettype none
// ============================================================================
// Module  : ins_seq
// Purpose : Multi-cycle RV32I instruction sequencer. Fetches over a req/ack
//           handshake, strobes the shared execute enable, captures execute
//           results and commits them in a dedicated writeback cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ins_seq_if.master - imem_req/addr/ack/rdata, ins, pc, exec_op,
//              exec_busy, reg_pc_w_*, reg_w_*, rf_we/waddr/wdata, trap/trap_pc
// Config  : INS_SEQ_MISALIGN_TRAP_EN - misaligned taken targets trap to
//           TRAP_VEC; when undefined target bits [1:0] are forced to 0 and
//           trap/trap_pc are tied 0.
// Revision: 1.0 - initial release
// ============================================================================
module ins_seq
  import ins_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic  clk,
  input  logic  rst,
  ins_seq_if.master bus
);

  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_TRAP   = ST_TRAP;

  logic [2:0]  state_q, state_d;
  logic [31:0] ins_q, ins_d;
  logic        imem_req_q, imem_req_d;
  logic        exec_op_q, exec_op_d;
  logic        cap_pc_w_op_q, cap_pc_w_op_d;
  logic [31:0] cap_pc_w_val_q, cap_pc_w_val_d;
  logic        cap_w_op_q, cap_w_op_d;
  logic [4:0]  cap_w_idx_q, cap_w_idx_d;
  logic [31:0] cap_w_val_q, cap_w_val_d;
  logic [31:0] pc;
  logic        misalign;
  logic        rf_we;

  always_comb begin
    state_d        = state_q;
    ins_d          = ins_q;
    cap_pc_w_op_d  = cap_pc_w_op_q;
    cap_pc_w_val_d = cap_pc_w_val_q;
    cap_w_op_d     = cap_w_op_q;
    cap_w_idx_d    = cap_w_idx_q;
    cap_w_val_d    = cap_w_val_q;
    case (state_q)
      // The request flop is low in the first cycle after reset, so an ack
      // left over from an abandoned fetch cannot be taken.
      S_FETCH: begin
        if (imem_req_q && bus.imem_ack) begin
          ins_d   = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!bus.exec_busy) begin
          cap_pc_w_op_d = bus.reg_pc_w_op;
`ifdef INS_SEQ_MISALIGN_TRAP_EN
          cap_pc_w_val_d = bus.reg_pc_w_val;
`else
          cap_pc_w_val_d = {bus.reg_pc_w_val[31:2], 2'b00};
`endif
          cap_w_op_d  = bus.reg_w_op;
          cap_w_idx_d = bus.reg_w_reg_idx;
          cap_w_val_d = bus.reg_w_reg_val;
          state_d     = S_WB;
        end
      end
      S_WB:    state_d = misalign ? S_TRAP : S_FETCH;
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Registered decodes of the next state keep imem_req / exec_op glitch-free.
  assign imem_req_d = (state_d == S_FETCH);
  assign exec_op_d  = (state_d == S_EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_FETCH;
      ins_q          <= '0;
      imem_req_q     <= 1'b0;
      exec_op_q      <= 1'b0;
      cap_pc_w_op_q  <= 1'b0;
      cap_pc_w_val_q <= '0;
      cap_w_op_q     <= 1'b0;
      cap_w_idx_q    <= '0;
      cap_w_val_q    <= '0;
    end else begin
      state_q        <= state_d;
      ins_q          <= ins_d;
      imem_req_q     <= imem_req_d;
      exec_op_q      <= exec_op_d;
      cap_pc_w_op_q  <= cap_pc_w_op_d;
      cap_pc_w_val_q <= cap_pc_w_val_d;
      cap_w_op_q     <= cap_w_op_d;
      cap_w_idx_q    <= cap_w_idx_d;
      cap_w_val_q    <= cap_w_val_d;
    end
  end

  ins_seq_pc #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .adv       (state_q == S_WB),
    .load_trap (state_q == S_TRAP),
    .tgt_op    (cap_pc_w_op_q),
    .tgt_val   (cap_pc_w_val_q),
    .pc        (pc),
    .misalign  (misalign)
  );

  // Writes to x0 and writes paired with a trapping target are dropped.
  assign rf_we = (state_q == S_WB) && cap_w_op_q && (cap_w_idx_q != 5'd0)
                 && !misalign;

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc;
  assign bus.ins       = ins_q;
  assign bus.pc        = pc;
  assign bus.exec_op   = exec_op_q;
  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_we ? cap_w_idx_q : 5'd0;
  assign bus.rf_wdata  = rf_we ? cap_w_val_q : 32'd0;

`ifdef INS_SEQ_MISALIGN_TRAP_EN
  logic [31:0] trap_pc_q, trap_pc_d;

  assign trap_pc_d = ((state_q == S_WB) && misalign) ? pc : trap_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_pc_q <= '0;
    else     trap_pc_q <= trap_pc_d;
  end

  assign bus.trap    = (state_q == S_TRAP);
  assign bus.trap_pc = trap_pc_q;
`else
  assign bus.trap    = 1'b0;
  assign bus.trap_pc = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ins_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ins_seq
// Purpose : Self-checking bench for ins_seq. Directed instructions push
//           their expected fetch / register-write / trap events into a
//           scoreboard queue; a monitor pops and compares as the DUT
//           presents them. Timing and quiet-output checks are made inline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ins_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int EV_FETCH = 0;
  localparam int EV_RF    = 1;
  localparam int EV_TRAP  = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic clk;
  logic rst;
  ins_seq_if bus();

  ev_t sb[$];
  int  checks;
  int  errors;
  int  exec_total;

  ins_seq #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic handle(input int kind, input logic [31:0] a,
                        input logic [31:0] b);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d a=%0h b=%0h required none",
               kind, a, b);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_a", {32'd0, a}, {32'd0, e.a});
      chk("event_b", {32'd0, b}, {32'd0, e.b});
    end
  endtask

  // Entered at posedge+1 with the DUT in FETCH and imem_req high.
  task automatic run_instr(input logic [31:0] addr, input int ack_dly,
                           input int busy, input logic pcw,
                           input logic [31:0] pcv, input logic wop,
                           input logic [4:0] idx, input logic [31:0] wval,
                           input logic [31:0] next_addr, input logic exp_rf,
                           input logic exp_trap, input logic spurious);
    int          e0;
    logic [31:0] word;
    word = addr ^ 32'h0000_0013;
    sb.push_back('{EV_FETCH, addr, 32'd0});
    if (exp_rf)   sb.push_back('{EV_RF, {27'd0, idx}, wval});
    if (exp_trap) sb.push_back('{EV_TRAP, addr, 32'd0});
    bus.reg_pc_w_op   = pcw;
    bus.reg_pc_w_val  = pcv;
    bus.reg_w_op      = wop;
    bus.reg_w_reg_idx = idx;
    bus.reg_w_reg_val = wval;
    e0 = exec_total;
    repeat (ack_dly) begin
      @(posedge clk); #1;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk("decode_ins", {32'd0, bus.ins}, {32'd0, word});
    chk("decode_exec_op", 64'(bus.exec_op), 64'd0);
    @(posedge clk); #1;
    bus.exec_busy = (busy > 0);
    if (spurious) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
    end
    for (int i = 0; i < busy; i++) begin
      @(posedge clk); #1;
      bus.imem_ack  = 1'b0;
      bus.exec_busy = (i + 1 < busy);
    end
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk("wb_quiet", {62'd0, bus.exec_op, bus.imem_req}, 64'd0);
    chk("wb_ins_kept", {32'd0, bus.ins}, {32'd0, word});
    chk("wb_pc_held", {32'd0, bus.pc}, {32'd0, addr});
    if (!exp_rf)
      chk("wb_rf_idle", {26'd0, bus.rf_we, bus.rf_waddr, bus.rf_wdata}, 64'd0);
    if (exp_trap) begin
      @(posedge clk); #1;
      chk("trap_pc_held", {32'd0, bus.pc}, {32'd0, addr});
    end
    @(posedge clk); #1;
    chk("refetch_req", 64'(bus.imem_req), 64'd1);
    chk("next_addr", {32'd0, bus.imem_addr}, {32'd0, next_addr});
    chk("exec_cycles", 64'(exec_total - e0), 64'(busy + 1));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exec_total = 0;
    rst        = 1'b1;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'd0;
    bus.exec_busy     = 1'b0;
    bus.reg_pc_w_op   = 1'b0;
    bus.reg_pc_w_val  = 32'd0;
    bus.reg_w_op      = 1'b0;
    bus.reg_w_reg_idx = 5'd0;
    bus.reg_w_reg_val = 32'd0;

    fork
      forever begin
        @(negedge clk);
        if (bus.exec_op) exec_total++;
        if (bus.imem_req && bus.imem_ack) handle(EV_FETCH, bus.imem_addr, 32'd0);
        if (bus.rf_we) handle(EV_RF, {27'd0, bus.rf_waddr}, bus.rf_wdata);
        if (bus.trap) handle(EV_TRAP, bus.trap_pc, 32'd0);
      end
    join_none

    // Reset state
    #12;
    chk("rst_outputs", {57'd0, bus.imem_req, bus.exec_op, bus.rf_we, bus.trap,
        |bus.rf_waddr, |bus.rf_wdata, |bus.trap_pc}, 64'd0);
    chk("rst_pc", {32'd0, bus.pc}, {32'd0, RESET_PC});
    chk("rst_ins", {32'd0, bus.ins}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("req_low_at_release", 64'(bus.imem_req), 64'd0);
    @(posedge clk); #1;
    chk("req_rise", 64'(bus.imem_req), 64'd1);
    chk("first_addr", {32'd0, bus.imem_addr}, {32'd0, RESET_PC});

    // NOP stream: 0, 4, 8, no register writes
    run_instr(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
    run_instr(32'h4, 0, 0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0);
    run_instr(32'h8, 0, 0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0);
    // PC write without register write
    run_instr(32'hC, 0, 0, 1'b1, 32'h40, 1'b0, 5'd0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0);
    // JAL x1 at 0x40
    run_instr(32'h40, 0, 0, 1'b1, 32'h80, 1'b1, 5'd1, 32'h44, 32'h80, 1'b1, 1'b0, 1'b0);
    // JAL x0: write dropped, PC still redirected
    run_instr(32'h80, 0, 0, 1'b1, 32'h100, 1'b1, 5'd0, 32'h55, 32'h100, 1'b0, 1'b0, 1'b0);
    // Register write only, 3-cycle ack delay, 2 busy cycles, spurious ack
    run_instr(32'h100, 3, 2, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h104,
              1'b1, 1'b0, 1'b1);
    // Wrap at top of address space
    run_instr(32'h104, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFC,
              1'b0, 1'b0, 1'b0);
    run_instr(32'hFFFF_FFFC, 0, 0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
              1'b0, 1'b0, 1'b0);
    run_instr(32'h0, 0, 1, 1'b1, 32'h10, 1'b0, 5'd0, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0);
    // Misaligned target 0x82 from 0x10 with a pending write to x3
`ifdef INS_SEQ_MISALIGN_TRAP_EN
    run_instr(32'h10, 0, 0, 1'b1, 32'h82, 1'b1, 5'd3, 32'h14, TRAP_VEC,
              1'b0, 1'b1, 1'b0);
`else
    run_instr(32'h10, 0, 0, 1'b1, 32'h82, 1'b1, 5'd3, 32'h14, 32'h80,
              1'b1, 1'b0, 1'b0);
`endif

    // Reset in the middle of a fetch, with a late ack around release
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_drop", 64'(bus.imem_req), 64'd0);
    chk("mid_rst_pc", {32'd0, bus.pc}, {32'd0, RESET_PC});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk("late_ack_ignored", {32'd0, bus.ins}, 64'd0);
    chk("restart_req", 64'(bus.imem_req), 64'd1);
    chk("restart_addr", {32'd0, bus.imem_addr}, {32'd0, RESET_PC});
    run_instr(32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
